huffman_decoder: RTL
====================

# huffman_decoder

Serial Huffman decoder: the receive-side counterpart of the Huffman coder. It accepts the coded bitstream one bit per handshake, MSB of each codeword first, and matches the accumulated prefix against the shared code table. It emits the 7-bit ASCII symbol through a valid/ready output port. It sits between the bit deserialiser on the TT pins and downstream symbol consumers.

## Interface
- `MAX_LEN`, default 10: longest codeword in bits; equals the coder's `huffman_out` width.
- `CNT_W`, default 4: width of the length counter; must hold `MAX_LEN`.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `bit_in` in 1: coded bit.
- `bit_valid` in 1: `bit_in` is valid.
- `bit_ready` out 1: decoder accepts a bit this cycle.
- `flush` in 1: synchronous clear of any partial codeword and of the error state.
- `ascii_out` out 7: decoded symbol.
- `ascii_valid` out 1: `ascii_out` is valid.
- `ascii_ready` in 1: consumer accepts the symbol.
- `error` out 1: sticky; `MAX_LEN` bits were accumulated with no table match.

## Operation
- **States:**
  - COLLECT: `bit_ready`=1.
  - HOLD: a symbol is pending; `bit_ready`=0.
  - ERR: `bit_ready`=0, `error`=1.
- **Accumulator:** `acc[MAX_LEN-1:0]` and `len[CNT_W-1:0]`.
  - On an accepted bit, `acc <= {acc[MAX_LEN-2:0], bit_in}` and `len <= len+1`.
  - The table lookup uses the post-shift value: `{acc, bit_in}` with length `len+1`.
- **Match in COLLECT:**
  - `ascii_out <=` symbol, `ascii_valid <= 1`.
  - `acc` and `len` clear to 0.
  - Go to HOLD.
- **No match with `len+1 == MAX_LEN`:** go to ERR; `acc` and `len` clear.
- **HOLD:** when `ascii_valid && ascii_ready`, `ascii_valid <= 0` and the state returns to COLLECT. There is no bypass, so `bit_ready` rises the following cycle.
- **ERR:** left only by `flush` or reset. Bits presented in ERR are not accepted.
- **`flush`:**
  - Highest priority over bit acceptance.
  - Clears `acc`, `len`, `error` and `ascii_valid`; state goes to COLLECT.
  - A pending symbol is dropped.
- **Reset values:** `ascii_out`=0, `ascii_valid`=0, `error`=0, state COLLECT; therefore `bit_ready`=1 once `rst_n` is high.
- **Reset mid-codeword or mid-HOLD:** all state is discarded immediately (asynchronous).
- **Output stability:** `ascii_out` holds its value while `ascii_valid`=1 and `ascii_ready`=0.

## Timing
- A bit is accepted on an edge where `bit_valid && bit_ready`.
- Latency: the last bit of a codeword is accepted at edge N, and `ascii_valid` is high from edge N onward (registered, no combinational path from `bit_in`).
- Throughput: one symbol per `len`+1 cycles when `ascii_ready` is held at 1. The extra cycle is the HOLD handoff.
- The `bit_ready` → `bit_valid` dependency is allowed; `bit_ready` depends only on the state register.

## Configuration
- **`HUFFMAN_DEC_STATS_EN` defined:**
  - Adds output `sym_count` (out, 16 bits).
  - Increments on every `ascii_valid && ascii_ready` handshake and wraps at 0xFFFF→0.
  - Cleared by reset and by `flush`.
- **Not defined:** the port and counter are absent; behaviour is otherwise identical.

## Structure
- **`huffman_pkg`**, shared with the coder:
  - `MAX_LEN`.
  - The code table as a constant array of {code[9:0], len[3:0], ascii[6:0]}.
  - The state enum `dec_state_t` {COLLECT, HOLD, ERR}.
- **Codeword `10'b1111111111`:** decided unassigned.
- **Sub-module `huffman_decode_table`:**
  - Combinational; takes {code, len} and returns {hit, ascii}.
  - The coder's table and this lookup are generated from the same package constant.

## Test plan
- **Single symbol:** reset, then code for 0x20 (`110`, len 3) with `ascii_ready`=1 → `ascii_valid` high for 1 cycle after the 3rd bit, `ascii_out`=0x20, then `bit_ready`=1 on the next cycle.
- **Backpressure:** `ascii_ready`=0 for 5 cycles after a match → `ascii_out` stable, `bit_ready`=0 throughout; with `ascii_ready`=1 the transfer takes one cycle.
- **Back-to-back string:** the stream encoding "HELLO" from the coder model → 5 symbols 0x48 0x45 0x4C 0x4C 0x4F in order, with no extra or missing pulses.
- **Error path:** ten 1-bits → `error`=1 after the 10th bit and `bit_ready`=0; then `flush` → `error`=0, and the next valid codeword decodes correctly.
- **Reset mid-codeword:** 2 bits of a 5-bit code, then `rst_n` low → all outputs at reset values; a full codeword after release decodes correctly.
- **`HUFFMAN_DEC_STATS_EN`:** 3 accepted symbols → `sym_count`=3; `flush` → 0.

Source files
------------

// File: rtl/huffman_pkg.sv
// Shared Huffman definitions: codeword width, code table and decoder state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package huffman_pkg;

  localparam int MAX_LEN   = 10;
  localparam int LEN_W     = 4;
  localparam int NUM_CODES = 12;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    ERR     = 2'd2
  } dec_state_t;

  // Codes are right-aligned: bit [len-1] is sent first and higher bits are zero.
  typedef struct packed {
    logic [MAX_LEN-1:0] code;
    logic [LEN_W-1:0]   len;
    logic [6:0]         ascii;
  } code_entry_t;

  // Prefix-free table. No all-ones prefix is assigned, so 10'b1111111111
  // (and every shorter run of ones) is guaranteed to miss.
  localparam code_entry_t CODE_TABLE [NUM_CODES] = '{
    '{10'b0000000110, 4'd3,  7'h20},  // ' '
    '{10'b0000000000, 4'd3,  7'h45},  // 'E'
    '{10'b0000000001, 4'd3,  7'h4C},  // 'L'
    '{10'b0000000100, 4'd4,  7'h48},  // 'H'
    '{10'b0000000101, 4'd4,  7'h4F},  // 'O'
    '{10'b0000000110, 4'd4,  7'h41},  // 'A'
    '{10'b0000000111, 4'd4,  7'h54},  // 'T'
    '{10'b0000010000, 4'd5,  7'h43},  // 'C'
    '{10'b0000010001, 4'd5,  7'h55},  // 'U'
    '{10'b0000010100, 4'd5,  7'h53},  // 'S'
    '{10'b0000010101, 4'd5,  7'h4E},  // 'N'
    '{10'b1110000000, 4'd10, 7'h5A}   // 'Z'
  };

endpackage

// File: rtl/huffman_dec_if.sv
// Bit-in / symbol-out bundle of the Huffman decoder; sym_count exists only with HUFFMAN_DEC_STATS_EN.
// Latency: n/a (wiring only).
// Backpressure: bit_ready throttles the bit source, ascii_ready throttles symbol delivery.
interface huffman_dec_if;

  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic       flush;
  logic [6:0] ascii_out;
  logic       ascii_valid;
  logic       ascii_ready;
  logic       error;
`ifdef HUFFMAN_DEC_STATS_EN
  logic [15:0] sym_count;

  modport master (
    output bit_in, bit_valid, flush, ascii_ready,
    input  bit_ready, ascii_out, ascii_valid, error, sym_count
  );

  modport slave (
    input  bit_in, bit_valid, flush, ascii_ready,
    output bit_ready, ascii_out, ascii_valid, error, sym_count
  );
`else
  modport master (
    output bit_in, bit_valid, flush, ascii_ready,
    input  bit_ready, ascii_out, ascii_valid, error
  );

  modport slave (
    input  bit_in, bit_valid, flush, ascii_ready,
    output bit_ready, ascii_out, ascii_valid, error
  );
`endif

endinterface

// File: rtl/huffman_decode_table.sv
// Combinational codeword lookup: {code, len} -> {hit, ascii} against the shared code table.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when the result is used.
module huffman_decode_table
  import huffman_pkg::*;
#(
  parameter int CODE_W = 11,
  parameter int CNT_W  = 4
) (
  input  logic [CODE_W-1:0] i_code,
  input  logic [CNT_W-1:0]  i_len,
  output logic              o_hit,
  output logic [6:0]        o_ascii
);

  // Scan every entry; the table is prefix-free so at most one can match.
  always_comb begin
    o_hit   = 1'b0;
    o_ascii = '0;
    for (int i = 0; i < NUM_CODES; i++) begin
      if ((i_len == CNT_W'(CODE_TABLE[i].len)) &&
          (i_code == CODE_W'(CODE_TABLE[i].code))) begin
        o_hit   = 1'b1;
        o_ascii = CODE_TABLE[i].ascii;
      end
    end
  end

endmodule

// File: rtl/huffman_decoder.sv
// Serial Huffman decoder, MSB-first bits in, 7-bit ASCII out; HUFFMAN_DEC_STATS_EN adds a 16-bit symbol counter.
// Latency: symbol valid on the edge that accepts its last bit; one HOLD handoff cycle per symbol.
// Backpressure: bit_ready drops while a symbol is pending or in error; ascii_out is held until accepted.
module huffman_decoder
  import huffman_pkg::*;
#(
  parameter int MAX_LEN = huffman_pkg::MAX_LEN,
  parameter int CNT_W   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  huffman_dec_if.slave  dec
);

  dec_state_t         r_state;
  dec_state_t         w_state_nxt;
  logic [MAX_LEN-1:0] r_acc;
  logic [CNT_W-1:0]   r_len;
  logic [6:0]         r_ascii;
  logic               r_ascii_vld;

  logic [MAX_LEN:0]   w_code;
  logic [CNT_W-1:0]   w_len;
  logic               w_hit;
  logic [6:0]         w_sym;
  logic               w_last;
  logic               w_bit_rdy;
  logic               w_err;
  logic               w_bit_acc;
  logic               w_out_hs;

  // Lookup sees the prefix as it will be after this bit shifts in.
  assign w_code    = {r_acc, dec.bit_in};
  assign w_len     = r_len + CNT_W'(1);
  assign w_last    = (w_len == CNT_W'(MAX_LEN));
  assign w_bit_acc = dec.bit_valid && w_bit_rdy;
  assign w_out_hs  = r_ascii_vld && dec.ascii_ready;

  huffman_decode_table #(
    .CODE_W (MAX_LEN + 1),
    .CNT_W  (CNT_W)
  ) u_table (
    .i_code  (w_code),
    .i_len   (w_len),
    .o_hit   (w_hit),
    .o_ascii (w_sym)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: flush wins over everything, ERR is left only by flush or reset.
  always_comb begin
    w_state_nxt = r_state;
    if (dec.flush) begin
      w_state_nxt = COLLECT;
    end else begin
      case (r_state)
        COLLECT: begin
          if (dec.bit_valid) begin
            if (w_hit) begin
              w_state_nxt = HOLD;
            end else if (w_last) begin
              w_state_nxt = ERR;
            end
          end
        end
        HOLD:    if (w_out_hs) w_state_nxt = COLLECT;
        ERR:     w_state_nxt = ERR;
        default: w_state_nxt = COLLECT;
      endcase
    end
  end

  // State-decoded outputs; bit_ready depends on the state register only.
  always_comb begin
    w_bit_rdy = 1'b0;
    w_err     = 1'b0;
    case (r_state)
      COLLECT: w_bit_rdy = 1'b1;
      ERR:     w_err     = 1'b1;
      default: ;
    endcase
  end

  // Accumulator and output symbol register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_len       <= '0;
      r_ascii     <= '0;
      r_ascii_vld <= 1'b0;
    end else if (dec.flush) begin
      r_acc       <= '0;
      r_len       <= '0;
      r_ascii_vld <= 1'b0;
    end else begin
      if (w_bit_acc) begin
        if (w_hit) begin
          r_ascii     <= w_sym;
          r_ascii_vld <= 1'b1;
          r_acc       <= '0;
          r_len       <= '0;
        end else if (w_last) begin
          r_acc <= '0;
          r_len <= '0;
        end else begin
          r_acc <= w_code[MAX_LEN-1:0];
          r_len <= w_len;
        end
      end
      if (w_out_hs) begin
        r_ascii_vld <= 1'b0;
      end
    end
  end

  assign dec.bit_ready   = w_bit_rdy;
  assign dec.error       = w_err;
  assign dec.ascii_out   = r_ascii;
  assign dec.ascii_valid = r_ascii_vld;

`ifdef HUFFMAN_DEC_STATS_EN
  logic [15:0] r_sym_cnt;

  // Count delivered symbols; wraps naturally, a flushed symbol is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sym_cnt <= '0;
    end else if (dec.flush) begin
      r_sym_cnt <= '0;
    end else if (w_out_hs) begin
      r_sym_cnt <= r_sym_cnt + 16'd1;
    end
  end

  assign dec.sym_count = r_sym_cnt;
`endif

endmodule
